kl8e_serial: RTL and testbench

- Console teletype interface (KL8E equivalent): UART receiver (keyboard/reader) and UART transmitter (printer/punch).
- Decodes IOTs 603x (keyboard) and 604x (printer); performs their side effects in F3.
- Upstream of the CPU IO multiplexer: drives serial_data_bus (read on 6034/6036) and sskip (honoured on 603x/604x).
- Drives a level interrupt request to the CPU.

---
 rtl/kl8e_serial_pkg.sv | 27 ++
 rtl/kl8e_serial_uart.sv | 153 +++++++++++++++
 rtl/kl8e_serial.sv | 92 +++++++++
 tb/tb_kl8e_serial.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kl8e_serial_pkg.sv
// Shared constants for the KL8E console interface: IOT codes, CPU state code, bit divider.
package kl8e_serial_pkg;

  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;

  localparam logic [11:0] KCF = 12'o6030;
  localparam logic [11:0] KSF = 12'o6031;
  localparam logic [11:0] KCC = 12'o6032;
  localparam logic [11:0] KRS = 12'o6034;
  localparam logic [11:0] KIE = 12'o6035;
  localparam logic [11:0] KRB = 12'o6036;
  localparam logic [11:0] SPF = 12'o6040;
  localparam logic [11:0] TSF = 12'o6041;
  localparam logic [11:0] TCF = 12'o6042;
  localparam logic [11:0] TPC = 12'o6044;
  localparam logic [11:0] TSK = 12'o6045;
  localparam logic [11:0] TLS = 12'o6046;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/kl8e_serial_uart.sv
// 8N1 bit engines for the console: RX with 2-FF synchroniser, TX with a one-deep hold register.
module kl8e_serial_uart
  import kl8e_serial_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       tx,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

  logic              rx_s1, rx_s2, rx_s3;
  uart_state_t       rx_st;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_sh;

  uart_state_t       tx_st;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [7:0]        tx_sh;
  logic [7:0]        hold;
  logic              hold_valid;

  // Stop bit is sampled but not checked; framing errors are deliberately ignored.
  assign rx_done = (rx_st == U_STOP) && (rx_cnt == DIV_M1);
  assign rx_byte = rx_sh;
  assign tx_done = (tx_st == U_STOP) && (tx_cnt == DIV_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      rx_st  <= U_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_st)
        U_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_st  <= U_START;
            rx_cnt <= '0;
          end
        end
        U_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? U_IDLE : U_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= U_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_st  <= U_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_st <= U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st      <= U_IDLE;
      tx         <= 1'b1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (tx_st)
        U_IDLE: begin
          if (hold_valid) begin
            tx_st      <= U_START;
            tx         <= 1'b0;
            tx_sh      <= hold;
            tx_cnt     <= '0;
            hold_valid <= 1'b0;
          end
        end
        U_START: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_st  <= U_DATA;
            tx     <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              tx_st <= U_STOP;
              tx    <= 1'b1;
            end else begin
              tx    <= tx_sh[0];
              tx_sh <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            tx_st  <= U_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_st <= U_IDLE;
      endcase
      // A load in the same clock as the hold is consumed keeps the new byte pending.
      if (tx_load) begin
        hold       <= tx_byte;
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/kl8e_serial.sv
// KL8E console teletype: IOT 603x/604x decode, flags, skip and interrupt around the UART engines.
// Optional macro KL8E_INT_ENABLE_EN adds the KIE (6035) interrupt-enable flip-flop.
module kl8e_serial
  import kl8e_serial_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic [11:0] instruction,
  input  logic [11:0] ac,
  input  logic        rx,
  output logic        tx,
  output logic [11:0] serial_data_bus,
  output logic        sskip,
  output logic        interrupt_request
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic       f3;
  logic       kbd_flag, prt_flag, ie;
  logic [7:0] kbd_buf;
  logic [7:0] rx_byte;
  logic       rx_done, tx_done, tx_load;
  logic       kbd_clr, prt_set, prt_clr;
  logic       unused_ac;

  assign f3      = (state == F3);
  assign tx_load = f3 && (instruction == TPC || instruction == TLS);
  assign kbd_clr = f3 && (instruction == KCF || instruction == KCC || instruction == KRB);
  assign prt_set = f3 && (instruction == SPF);
  assign prt_clr = f3 && (instruction == TCF || instruction == TLS);
  assign unused_ac = ^ac[11:8];

  // Vector bit 0 is PDP-8 AC bit 11, so AC[4:11] is ac[7:0].
  kl8e_serial_uart #(.DIV(DIV)) u_serial_uart (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_byte (rx_byte),
    .rx_done (rx_done),
    .tx      (tx),
    .tx_byte (ac[7:0]),
    .tx_load (tx_load),
    .tx_done (tx_done)
  );

`ifdef KL8E_INT_ENABLE_EN
  always_ff @(posedge clk) begin
    if (reset)                          ie <= 1'b1;
    else if (f3 && instruction == KIE)  ie <= ac[0];
  end
`else
  assign ie = 1'b1;
`endif

  always_comb begin
    sskip = 1'b0;
    case (instruction)
      KSF:     sskip = kbd_flag;
      TSF:     sskip = prt_flag;
      TSK:     sskip = kbd_flag | prt_flag;
      default: sskip = 1'b0;
    endcase
  end

  // Hardware flag sets take priority over IOT clears in the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_flag          <= 1'b0;
      prt_flag          <= 1'b0;
      kbd_buf           <= 8'h00;
      serial_data_bus   <= 12'o0000;
      interrupt_request <= 1'b0;
    end else begin
      serial_data_bus   <= {4'o0, kbd_buf};
      interrupt_request <= ie & (kbd_flag | prt_flag);
      if (rx_done) begin
        kbd_flag <= 1'b1;
        kbd_buf  <= rx_byte;
      end else if (kbd_clr) begin
        kbd_flag <= 1'b0;
      end
      if (tx_done || prt_set) prt_flag <= 1'b1;
      else if (prt_clr)       prt_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kl8e_serial.sv
// Randomised bench for kl8e_serial: drives serial frames and IOTs, checks against a flag/byte-level model.
module tb_kl8e_serial;
  import kl8e_serial_pkg::*;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam logic [11:0] NOP = 12'o7000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  state;
  logic [11:0] instruction, ac;
  logic        rx, tx, sskip, interrupt_request;
  logic [11:0] serial_data_bus;

  kl8e_serial #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk               (clk),
    .reset             (reset),
    .state             (state),
    .instruction       (instruction),
    .ac                (ac),
    .rx                (rx),
    .tx                (tx),
    .serial_data_bus   (serial_data_bus),
    .sskip             (sskip),
    .interrupt_request (interrupt_request)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: architectural flags, buffer and the byte stream the line must carry.
  logic       exp_kbd, exp_prt, exp_ie;
  logic [7:0] exp_buf;
  logic [7:0] exp_tx[$];
  logic [7:0] tx_seen[$];
  int         tx_start[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic iot(input logic [11:0] code);
    state = F3; instruction = code;
    tick();
    state = F1; instruction = NOP;
  endtask

  task automatic check_flags(input string tag);
    instruction = KSF; #1;
    check_val({tag, ".ksf"}, 32'(sskip), 32'(exp_kbd));
    instruction = TSF; #1;
    check_val({tag, ".tsf"}, 32'(sskip), 32'(exp_prt));
    instruction = TSK; #1;
    check_val({tag, ".tsk"}, 32'(sskip), 32'(exp_kbd | exp_prt));
    instruction = KIE; #1;
    check_val({tag, ".kie_skip"}, 32'(sskip), 32'd0);
    instruction = NOP;
    check_val({tag, ".sdb"}, 32'(serial_data_bus), 32'({4'o0, exp_buf}));
    check_val({tag, ".irq"}, 32'(interrupt_request), 32'(exp_ie & (exp_kbd | exp_prt)));
  endtask

  // Sends one 8N1 frame; optionally issues KRB at tick clr_at of the stop window.
  task automatic send_rx(input logic [7:0] b, input int clr_at, output int done_at);
    done_at = -1;
    instruction = KSF;
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = 1'b1;
    for (int t = 0; t < 3 * DIV; t++) begin
      if (t == clr_at) begin state = F3; instruction = KRB; end
      tick();
      state = F1; instruction = KSF; #1;
      if (done_at < 0 && sskip) done_at = t;
    end
    instruction = NOP;
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (tx_seen.size() < n && t < 30 * DIV) begin tick(); t++; end
    check_val("tx.count", 32'(tx_seen.size()), 32'(n));
  endtask

  task automatic compare_tx();
    for (int i = 0; i < exp_tx.size(); i++)
      check_val("tx.byte", (i < tx_seen.size()) ? 32'(tx_seen[i]) : 32'hFFFF_FFFF, 32'(exp_tx[i]));
  endtask

  // Line monitor: decodes frames at mid-bit and records their start cycle.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] mb;
    int         st;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev && !tx && !reset) begin
        st = cyc;
        repeat (DIV / 2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) begin @(posedge clk); #1; end
          mb[i] = tx;
        end
        repeat (DIV) begin @(posedge clk); #1; end
        check_val("tx.stop_bit", 32'(tx), 32'd1);
        tx_seen.push_back(mb);
        tx_start.push_back(st);
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    int         lat, d2, c0;
    logic [7:0] b;
    reset = 1'b1; state = F1; instruction = NOP; ac = 12'o0000; rx = 1'b1;
    exp_kbd = 1'b0; exp_prt = 1'b0; exp_ie = 1'b1; exp_buf = 8'h00;
    repeat (3) tick();
    check_val("rst.tx", 32'(tx), 32'd1);
    reset = 1'b0;
    repeat (2) tick();
    check_flags("reset");

    send_rx(8'h8D, -1, lat);
    exp_kbd = 1'b1; exp_buf = 8'h8D;
    check_val("rx.latency_in_stop", 32'(lat >= 0 && lat < 2 * DIV), 32'd1);
    check_flags("rx8d");

    // Overrun: flag already set, buffer overwritten.
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, -1, d2);
      exp_buf = b;
      check_flags("rx_rand");
    end

    iot(KRS); tick(); check_flags("krs");
    iot(KRB); exp_kbd = 1'b0; tick(); check_flags("krb");

    // RX completion coincident with KRB: the set wins.
    b = 8'($urandom_range(0, 255));
    send_rx(b, lat, d2);
    exp_kbd = 1'b1; exp_buf = b;
    check_val("coll.flag_kept", 32'(d2), 32'(lat));
    check_flags("coll");

    iot(KCF); exp_kbd = 1'b0; tick(); check_flags("kcf");
    b = 8'($urandom_range(0, 255));
    send_rx(b, -1, d2); exp_kbd = 1'b1; exp_buf = b;
    check_flags("rx_again");
    iot(KCC); exp_kbd = 1'b0; tick(); check_flags("kcc");

    iot(SPF); exp_prt = 1'b1; tick(); check_flags("spf");
    ac = 12'o0301; c0 = cyc;
    iot(TLS); exp_prt = 1'b0; exp_tx.push_back(8'hC1);
    tick(); check_flags("tls");
    wait_tx(1);
    check_val("tx.start_latency", 32'(tx_start[0] - c0 >= 1 && tx_start[0] - c0 <= 3), 32'd1);
    repeat (DIV) tick();
    exp_prt = 1'b1;
    check_flags("tx_done");

    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      ac = {4'o0, b};
      iot(TPC); exp_tx.push_back(b);
      wait_tx(exp_tx.size());
      repeat (DIV) tick();
    end

    // Two loads while busy: only the last one is sent, back-to-back.
    b = 8'($urandom_range(0, 255));
    ac = {4'o0, b};
    iot(TPC); exp_tx.push_back(b);
    repeat (3 * DIV) tick();
    ac = 12'o0101; iot(TPC);
    repeat (DIV) tick();
    ac = 12'o0102; iot(TPC); exp_tx.push_back(8'h42);
    wait_tx(exp_tx.size());
    check_val("tx.back_to_back",
              32'(tx_start[exp_tx.size() - 1] - tx_start[exp_tx.size() - 2] >= 10 * DIV &&
                  tx_start[exp_tx.size() - 1] - tx_start[exp_tx.size() - 2] <= 10 * DIV + 3), 32'd1);
    repeat (15 * DIV) tick();
    check_val("tx.no_extra", 32'(tx_seen.size()), 32'(exp_tx.size()));
    compare_tx();
    check_flags("tx_burst");
    iot(TCF); exp_prt = 1'b0; tick(); check_flags("tcf");

    // Short low pulse is rejected and the receiver still accepts the next frame.
    rx = 1'b0; repeat (4) tick(); rx = 1'b1;
    repeat (3 * DIV) tick();
    check_flags("glitch");
    b = 8'($urandom_range(0, 255));
    send_rx(b, -1, d2); exp_kbd = 1'b1; exp_buf = b;
    check_flags("post_glitch");

    // Reset in the middle of a frame.
    iot(SPF); exp_prt = 1'b1;
    ac = {4'o0, 8'($urandom_range(0, 255))};
    iot(TPC);
    repeat (3 * DIV) tick();
    reset = 1'b1;
    tick();
    exp_kbd = 1'b0; exp_prt = 1'b0; exp_buf = 8'h00;
    check_val("rst_mid.tx", 32'(tx), 32'd1);
    check_flags("rst_mid");
    reset = 1'b0;
    repeat (12 * DIV) tick();
    check_val("rst_mid.line_idle", 32'(tx), 32'd1);
    tx_seen.delete(); tx_start.delete(); exp_tx.delete();

    b = 8'($urandom_range(0, 255));
    ac = {4'o0, b};
    iot(TPC); exp_tx.push_back(b);
    wait_tx(1);
    repeat (DIV) tick();
    exp_prt = 1'b1;
    compare_tx();
    check_flags("post_rst_tx");

`ifdef KL8E_INT_ENABLE_EN
    ac = 12'o0000; iot(KIE); exp_ie = 1'b0;
    tick();
    check_flags("kie_off");
    b = 8'($urandom_range(0, 255));
    send_rx(b, -1, d2); exp_kbd = 1'b1; exp_buf = b;
    check_flags("kie_off_rx");
    ac = 12'o0001; iot(KIE); exp_ie = 1'b1;
    tick();
    check_val("kie_on.irq", 32'(interrupt_request), 32'd1);
    check_flags("kie_on");
`else
    ac = 12'o0000; iot(KIE);
    tick();
    check_flags("kie_noop");
    b = 8'($urandom_range(0, 255));
    send_rx(b, -1, d2); exp_kbd = 1'b1; exp_buf = b;
    check_flags("kie_noop_rx");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
